dutb_stream_checker: RTL
========================

DUTB_STREAM_CHECKER -- requirements
Module: dutb_stream_checker

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 32, the compared data width in bits.
REQ-002 SHALL have parameter P_FIFO_DEPTH, default 8, the number of expected-FIFO entries, a power of 2 and at least 2.
REQ-003 SHALL have parameter P_MAX_FAIL_NUM, default 16, the number of mismatches that asserts stop.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports clk and rst.
REQ-005 SHALL have these ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- exp_valid  input  1  expected word offered
- exp_ready  output  1  expected word accepted
- exp_data  input  P_DATA_WIDTH  expected word
- act_valid  input  1  DUT output word offered
- act_ready  output  1  DUT output word accepted
- act_data  input  P_DATA_WIDTH  DUT output word
- pass_cnt  output  16  matching compares
- fail_cnt  output  16  mismatching compares
- stop  output  1  fail limit reached
- orphan  output  1  actual word arrived with the FIFO empty (sticky)
- fifo_level  output  $clog2(P_FIFO_DEPTH)+1  current FIFO occupancy

Function
REQ-006 SHALL buffer expected words in a FIFO; exp_ready = (level < P_FIFO_DEPTH) and state != STOPPED.
REQ-007 SHALL set act_ready = 1 in RUN and 0 in STOPPED.
REQ-008 SHALL treat an act beat (act_valid and act_ready) with a non-empty FIFO as a compare:
- pop the FIFO head
- if head == act_data, increment pass_cnt on the next edge
- otherwise, increment fail_cnt on the next edge
- latency: one cycle from the beat to the counter update
REQ-009 SHALL handle an act beat with an empty FIFO as follows:
- set orphan, held until reset
- leave the counters unchanged
- do not compare against a same-cycle exp write (no bypass path)
REQ-010 SHALL allow a push and a pop in the same cycle, including when full (a pop frees the slot) and when empty (push only, because the pop is illegal per REQ-009); fifo_level is then unchanged, or +1 in the empty case.
REQ-011 SHALL wrap the read and write pointers modulo P_FIFO_DEPTH.
REQ-012 SHALL implement the state machine:
- RUN -> STOPPED when a mismatch raises fail_cnt to P_MAX_FAIL_NUM
- STOPPED is left only by rst
REQ-013 SHALL drive stop = 1 exactly while in STOPPED.
REQ-014 SHALL saturate pass_cnt and fail_cnt at 16'hFFFF without wrapping.
REQ-015 SHALL, with P_MAX_FAIL_NUM = 0, never enter STOPPED.

Reset
REQ-016 SHALL, on rst high at a clk edge, set:
- state = RUN
- pass_cnt = 0, fail_cnt = 0, orphan = 0, fifo_level = 0
- both pointers = 0
REQ-017 SHALL, with rst high, hold exp_ready = 0, act_ready = 0 and stop = 0.
REQ-018 SHALL discard FIFO contents when rst asserts mid-stream; the first post-reset act beat is therefore an orphan unless exp data is pushed first.

Configuration
REQ-019 SHALL, with macro DUTB_CHK_LAST_FAIL_EN defined:
- add outputs last_fail_exp and last_fail_act, each P_DATA_WIDTH wide
- capture both operands of the most recent mismatch on the same edge as fail_cnt
- reset both to 0
REQ-020 SHALL, without DUTB_CHK_LAST_FAIL_EN, omit those ports and registers; all other behaviour is identical.

Verification
REQ-021 Push exp 0x11, 0x22, 0x33 then send act 0x11, 0x22, 0x33 -> pass_cnt = 3, fail_cnt = 0, fifo_level = 0, stop = 0.
REQ-022 P_MAX_FAIL_NUM = 4; push and send 4 mismatching pairs -> fail_cnt = 4 one cycle after the 4th beat, stop = 1, act_ready = 0, exp_ready = 0; further stimulus changes nothing.
REQ-023 Fill FIFO to 8 -> exp_ready = 0; simultaneous push and act beat at full -> level stays 8 and compare uses the oldest entry; run 20 push/pop pairs to cover pointer wrap.
REQ-024 Act beat 0x5 with an empty FIFO and a same-cycle exp push of 0x5 -> orphan = 1, counters 0, fifo_level = 1.
REQ-025 Assert rst with 5 entries queued and fail_cnt = 2 -> next cycle all counters 0, level 0, state RUN.
REQ-026 With DUTB_CHK_LAST_FAIL_EN, exp 0xA5 vs act 0x5A -> last_fail_exp = 0xA5, last_fail_act = 0x5A; a later matching pair leaves them unchanged.

Source files
------------

// File: rtl/dutb_stream_checker.sv
// Scoreboard checker: queues expected words, compares them in order against DUT output words.
// Optional capture of the last mismatching operand pair when DUTB_CHK_LAST_FAIL_EN is defined.
module dutb_stream_checker #(
  parameter int unsigned P_DATA_WIDTH   = 32,
  parameter int unsigned P_FIFO_DEPTH   = 8,
  parameter int unsigned P_MAX_FAIL_NUM = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              exp_valid,
  output logic                              exp_ready,
  input  logic [P_DATA_WIDTH-1:0]           exp_data,
  input  logic                              act_valid,
  output logic                              act_ready,
  input  logic [P_DATA_WIDTH-1:0]           act_data,
  output logic [15:0]                       pass_cnt,
  output logic [15:0]                       fail_cnt,
  output logic                              stop,
  output logic                              orphan,
  output logic [$clog2(P_FIFO_DEPTH):0]     fifo_level
`ifdef DUTB_CHK_LAST_FAIL_EN
  ,
  output logic [P_DATA_WIDTH-1:0]           last_fail_exp,
  output logic [P_DATA_WIDTH-1:0]           last_fail_act
`endif
);

  localparam int unsigned AW = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  typedef enum logic {
    RUN     = 1'b0,
    STOPPED = 1'b1
  } state_t;

  state_t                  state;
  logic [P_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;

  logic        running;
  logic        empty;
  logic        full;
  logic        act_beat;
  logic        push;
  logic        pop;
  logic        match;
  logic [15:0] pass_nxt;
  logic [15:0] fail_nxt;
  logic        stop_hit;

  assign running  = (state == RUN) && !rst;
  assign empty    = (fifo_level == '0);
  assign full     = (fifo_level == LW'(P_FIFO_DEPTH));
  assign act_beat = act_valid && act_ready;
  assign pop      = act_beat && !empty;
  assign push     = exp_valid && exp_ready;

  // A same-cycle pop frees the head slot, so a full FIFO can still accept a word.
  assign exp_ready = running && (!full || pop);
  assign act_ready = running;
  assign stop      = (state == STOPPED) && !rst;

  assign match    = (mem[rd_ptr] == act_data);
  assign pass_nxt = (pass_cnt == 16'hFFFF) ? pass_cnt : pass_cnt + 16'd1;
  assign fail_nxt = (fail_cnt == 16'hFFFF) ? fail_cnt : fail_cnt + 16'd1;
  assign stop_hit = (P_MAX_FAIL_NUM != 0) && ({16'h0000, fail_nxt} == 32'(P_MAX_FAIL_NUM));

  // Expected-word storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= exp_data;
  end

  // Control, pointers, counters and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      orphan     <= 1'b0;
`ifdef DUTB_CHK_LAST_FAIL_EN
      last_fail_exp <= '0;
      last_fail_act <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase

      // Empty-FIFO beats never compare, even against a word pushed this cycle.
      if (act_beat && empty) orphan <= 1'b1;

      if (pop) begin
        if (match) begin
          pass_cnt <= pass_nxt;
        end else begin
          fail_cnt <= fail_nxt;
`ifdef DUTB_CHK_LAST_FAIL_EN
          last_fail_exp <= mem[rd_ptr];
          last_fail_act <= act_data;
`endif
          if (stop_hit) state <= STOPPED;
        end
      end
    end
  end

endmodule
